// File: rtl/hp_alarm_mon.sv
// hp_alarm_mon: qualifies the phase-detector Alarm into a sticky tamper flag.
// Alarm is synchronized, ignored until a clean warm-up window has elapsed,
// trips on a run of consecutive alarm cycles, counts trips and can lock out.
module hp_alarm_mon #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned WARMUP_CYCLES = 16,
   parameter int unsigned TRIP_THRESH   = 1,
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned LOCK_COUNT    = 4
) (
   input  logic             CK,
   input  logic             RST_N,
   input  logic             en,
   input  logic             Alarm,
   input  logic             clr_req,
   output logic             clr_ack,
   output logic             armed,
   output logic             tamper,
   output logic             tamper_pulse,
   output logic             locked,
   output logic [CNT_W-1:0] event_cnt,
   output logic [2:0]       state
);

   // Counters only ever reach threshold-1, so clog2 of the threshold suffices.
   localparam int unsigned WU_W  = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
   localparam int unsigned RUN_W = (TRIP_THRESH > 1) ? $clog2(TRIP_THRESH) : 1;

   typedef enum logic [2:0] {
      S_DISARMED = 3'd0,
      S_WARMUP   = 3'd1,
      S_ARMED    = 3'd2,
      S_TRIPPED  = 3'd3,
      S_LOCKED   = 3'd4
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [WU_W-1:0]        wu_q;
   logic [RUN_W-1:0]       run_q;
   logic [CNT_W-1:0]       event_cnt_q;
   logic [CNT_W-1:0]       event_cnt_d;
   logic                   tamper_q;
   logic                   pulse_q;
   logic                   ack_q;

   logic                   alarm_s;
   logic                   wu_done;
   logic                   run_hit;
   logic                   lock_hit;

   // Alarm synchronizer; only the last stage feeds any decision.
   always_ff @(posedge CK) begin
      if (!RST_N) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], Alarm};
      end
   end

   // Threshold decodes and the saturated trip count a trip would produce.
   always_comb begin
      alarm_s     = sync_q[SYNC_STAGES-1];
      wu_done     = (wu_q == WU_W'(WARMUP_CYCLES - 1));
      run_hit     = (run_q == RUN_W'(TRIP_THRESH - 1));
      event_cnt_d = (event_cnt_q == '1) ? event_cnt_q : event_cnt_q + CNT_W'(1);
      lock_hit    = (LOCK_COUNT != 0) && (32'(event_cnt_d) >= LOCK_COUNT);
   end

   // Monitor FSM with its counters and registered flags.
   always_ff @(posedge CK) begin
      if (!RST_N) begin
         state_q     <= S_DISARMED;
         wu_q        <= '0;
         run_q       <= '0;
         event_cnt_q <= '0;
         tamper_q    <= 1'b0;
         pulse_q     <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         ack_q   <= 1'b0;
         unique case (state_q)
            S_DISARMED: begin
               wu_q  <= '0;
               run_q <= '0;
               if (en) begin
                  state_q <= S_WARMUP;
               end
            end
            S_WARMUP: begin
               run_q <= '0;
               if (!en) begin
                  state_q <= S_DISARMED;
                  wu_q    <= '0;
               end else if (alarm_s) begin
                  wu_q <= '0;
               end else if (wu_done) begin
                  state_q <= S_ARMED;
                  wu_q    <= '0;
               end else begin
                  wu_q <= wu_q + WU_W'(1);
               end
            end
            S_ARMED: begin
               wu_q <= '0;
               // A trip takes priority over a simultaneous disable.
               if (alarm_s && run_hit) begin
                  event_cnt_q <= event_cnt_d;
                  tamper_q    <= 1'b1;
                  pulse_q     <= 1'b1;
                  run_q       <= '0;
                  state_q     <= lock_hit ? S_LOCKED : S_TRIPPED;
               end else if (!en) begin
                  state_q <= S_DISARMED;
                  run_q   <= '0;
               end else if (alarm_s) begin
                  run_q <= run_q + RUN_W'(1);
               end else begin
                  run_q <= '0;
               end
            end
            S_TRIPPED: begin
               if (clr_req) begin
                  ack_q    <= 1'b1;
                  tamper_q <= 1'b0;
                  state_q  <= en ? S_WARMUP : S_DISARMED;
               end
            end
            S_LOCKED: begin
               tamper_q <= 1'b1;
            end
            default: begin
               state_q <= S_DISARMED;
            end
         endcase
      end
   end

   assign state        = state_q;
   assign armed        = (state_q == S_ARMED);
   assign locked       = (state_q == S_LOCKED);
   assign tamper       = tamper_q;
   assign tamper_pulse = pulse_q;
   assign clr_ack      = ack_q;
   assign event_cnt    = event_cnt_q;

endmodule

// File: tb/tb_hp_alarm_mon.sv
// Scoreboard bench for hp_alarm_mon: two parameterizations share one stimulus
// stream; a reference model pushes expected outputs per clock and a monitor
// pops and compares them on the falling edge.
module tb_hp_alarm_mon;

   localparam int unsigned A_SYNC = 2, A_WARM = 16, A_THR = 3, A_CW = 8, A_LOCK = 4;
   localparam int unsigned B_SYNC = 3, B_WARM = 16, B_THR = 1, B_CW = 2, B_LOCK = 0;

   logic CK = 1'b0;
   logic RST_N = 1'b0;
   logic en = 1'b0;
   logic Alarm = 1'b0;
   logic clr_req = 1'b0;

   logic            a_ack, a_armed, a_tamper, a_pulse, a_locked;
   logic [A_CW-1:0] a_cnt;
   logic [2:0]      a_state;
   logic            b_ack, b_armed, b_tamper, b_pulse, b_locked;
   logic [B_CW-1:0] b_cnt;
   logic [2:0]      b_state;

   hp_alarm_mon #(.SYNC_STAGES(A_SYNC), .WARMUP_CYCLES(A_WARM), .TRIP_THRESH(A_THR),
                  .CNT_W(A_CW), .LOCK_COUNT(A_LOCK)) u_a (
      .CK(CK), .RST_N(RST_N), .en(en), .Alarm(Alarm), .clr_req(clr_req),
      .clr_ack(a_ack), .armed(a_armed), .tamper(a_tamper), .tamper_pulse(a_pulse),
      .locked(a_locked), .event_cnt(a_cnt), .state(a_state));

   hp_alarm_mon #(.SYNC_STAGES(B_SYNC), .WARMUP_CYCLES(B_WARM), .TRIP_THRESH(B_THR),
                  .CNT_W(B_CW), .LOCK_COUNT(B_LOCK)) u_b (
      .CK(CK), .RST_N(RST_N), .en(en), .Alarm(Alarm), .clr_req(clr_req),
      .clr_ack(b_ack), .armed(b_armed), .tamper(b_tamper), .tamper_pulse(b_pulse),
      .locked(b_locked), .event_cnt(b_cnt), .state(b_state));

   always #5 CK = ~CK;

   typedef struct packed {
      logic [2:0] st;
      logic       armed;
      logic       locked;
      logic       tamper;
      logic       pulse;
      logic       ack;
      logic [7:0] cnt;
   } obs_t;

   typedef struct {
      int st;   // 0 disarmed, 1 warmup, 2 armed, 3 tripped, 4 locked
      int wu;   // clean cycles seen in warm-up
      int run;  // consecutive alarm cycles seen while armed
      int cnt;
      bit tamper;
      bit pulse;
      bit ack;
   } mdl_t;

   mdl_t ma, mb;
   bit   hist_a[$], hist_b[$];
   obs_t exp_a[$], exp_b[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc_no = 0;

   function automatic mdl_t step(input mdl_t m, input bit rst, input bit en_i,
                                 input bit as, input bit clr, input int thr,
                                 input int lock, input int cmax, input int wcyc);
      mdl_t r = m;
      r.pulse = 1'b0;
      r.ack   = 1'b0;
      if (rst) begin
         r.st = 0; r.wu = 0; r.run = 0; r.cnt = 0; r.tamper = 1'b0;
         return r;
      end
      if (m.st == 0) begin
         if (en_i) r.st = 1;
      end else if (m.st == 1) begin
         if (!en_i) begin r.st = 0; r.wu = 0; end
         else if (as) r.wu = 0;
         else if (m.wu + 1 == wcyc) begin r.st = 2; r.wu = 0; end
         else r.wu = m.wu + 1;
      end else if (m.st == 2) begin
         if (as && m.run + 1 == thr) begin
            if (m.cnt < cmax) r.cnt = m.cnt + 1;
            r.tamper = 1'b1;
            r.pulse  = 1'b1;
            r.run    = 0;
            r.st     = (lock != 0 && r.cnt >= lock) ? 4 : 3;
         end else if (!en_i) begin r.st = 0; r.run = 0; end
         else if (as) r.run = m.run + 1;
         else r.run = 0;
      end else if (m.st == 3) begin
         if (clr) begin
            r.ack = 1'b1; r.tamper = 1'b0; r.st = en_i ? 1 : 0;
         end
      end
      return r;
   endfunction

   function automatic obs_t to_obs(input mdl_t m);
      obs_t o;
      o.st     = 3'(m.st);
      o.armed  = (m.st == 2);
      o.locked = (m.st == 4);
      o.tamper = m.tamper;
      o.pulse  = m.pulse;
      o.ack    = m.ack;
      o.cnt    = 8'(m.cnt);
      return o;
   endfunction

   // Reference model: advance on each clock edge and queue the expected outputs.
   always @(posedge CK) begin
      bit as_a, as_b;
      as_a = 1'b0;
      as_b = 1'b0;
      if (!RST_N) begin
         hist_a.delete();
         hist_b.delete();
         for (int i = 0; i < int'(A_SYNC); i++) hist_a.push_back(1'b0);
         for (int i = 0; i < int'(B_SYNC); i++) hist_b.push_back(1'b0);
      end else begin
         as_a = hist_a.pop_front();
         as_b = hist_b.pop_front();
         hist_a.push_back(Alarm);
         hist_b.push_back(Alarm);
      end
      ma = step(ma, !RST_N, en, as_a, clr_req, A_THR, A_LOCK, (1 << A_CW) - 1, A_WARM);
      mb = step(mb, !RST_N, en, as_b, clr_req, B_THR, B_LOCK, (1 << B_CW) - 1, B_WARM);
      exp_a.push_back(to_obs(ma));
      exp_b.push_back(to_obs(mb));
   end

   task automatic check(input string nm, input obs_t got, input obs_t want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got st=%0d arm=%b lck=%b tmp=%b pls=%b ack=%b cnt=%0d, expected st=%0d arm=%b lck=%b tmp=%b pls=%b ack=%b cnt=%0d",
                  nm, cyc_no, got.st, got.armed, got.locked, got.tamper, got.pulse, got.ack, got.cnt,
                  want.st, want.armed, want.locked, want.tamper, want.pulse, want.ack, want.cnt);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare away from the edge.
   always @(negedge CK) begin
      obs_t ga, gb;
      cyc_no++;
      ga = {a_state, a_armed, a_locked, a_tamper, a_pulse, a_ack, 8'(a_cnt)};
      gb = {b_state, b_armed, b_locked, b_tamper, b_pulse, b_ack, 8'(b_cnt)};
      if (exp_a.size() > 0) check("dut_a", ga, exp_a.pop_front());
      if (exp_b.size() > 0) check("dut_b", gb, exp_b.pop_front());
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge CK);
   endtask

   initial begin
      int run_left;
      run_left = 0;
      cyc(3);
      RST_N = 1'b1;
      cyc(3);
      // Alarm stuck high: never leaves warm-up.
      en = 1'b1; Alarm = 1'b1;
      cyc(50);
      // Clean window interrupted by one alarm cycle, then arm.
      Alarm = 1'b0; cyc(10);
      Alarm = 1'b1; cyc(1);
      Alarm = 1'b0; cyc(30);
      // Short run below threshold, then a qualifying run.
      Alarm = 1'b1; cyc(2);
      Alarm = 1'b0; cyc(6);
      Alarm = 1'b1; cyc(3);
      Alarm = 1'b0; cyc(6);
      // Held clear request: one acknowledge per tripped visit.
      clr_req = 1'b1; cyc(5);
      clr_req = 1'b0; cyc(25);
      // Repeated trip/clear drives lockout on A and saturation on B.
      for (int k = 0; k < 6; k++) begin
         Alarm = 1'b1; cyc(4);
         Alarm = 1'b0; cyc(3);
         if (k == 4) begin
            en = 1'b0; cyc(4);
         end
         clr_req = 1'b1; cyc(3);
         clr_req = 1'b0; en = 1'b1; cyc(25);
      end
      // Clear and disable attempts while locked.
      clr_req = 1'b1; en = 1'b0; cyc(10);
      clr_req = 1'b0; en = 1'b1; cyc(3);
      RST_N = 1'b0; cyc(2);
      RST_N = 1'b1; cyc(2);
      // Randomized bursty traffic with occasional disable, clear and reset.
      for (int i = 0; i < 3000; i++) begin
         if (run_left == 0) begin
            Alarm = ~Alarm;
            run_left = Alarm ? int'($urandom_range(1, 5)) : int'($urandom_range(1, 24));
         end
         run_left--;
         en      = ($urandom_range(0, 99) < 96);
         clr_req = ($urandom_range(0, 99) < 8);
         RST_N   = ($urandom_range(0, 499) != 0);
         cyc(1);
      end
      RST_N = 1'b1; clr_req = 1'b0; Alarm = 1'b0;
      cyc(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hp_alarm_mon.md
Name: hp_alarm_mon

Overview:
- Downstream consumer of the hoggephase phase-detector Alarm output. Turns the raw, glitch-prone Alarm into a qualified, sticky tamper indication for the security controller.
- Synchronizes Alarm and ignores it during oscillator warm-up, when Alarm is legitimately high because Data is not yet toggling.
- Trips on a run of consecutive alarm cycles, counts trip events, and locks out permanently after too many.

Parameters:
- SYNC_STAGES, 2, flops in the Alarm synchronizer (minimum 2).
- WARMUP_CYCLES, 16, consecutive clean synchronized cycles required before arming (minimum 1).
- TRIP_THRESH, 1, consecutive synchronized alarm cycles required to trip (minimum 1).
- CNT_W, 8, width of the trip event counter.
- LOCK_COUNT, 4, trip count that forces LOCKED. 0 disables lockout.

Ports:
- CK  input  1  system clock, all logic on posedge.
- RST_N  input  1  synchronous active-low reset.
- en  input  1  monitor enable.
- Alarm  input  1  raw alarm from the phase detector, asynchronous to CK.
- clr_req  input  1  request to clear a trip (level).
- clr_ack  output  1  one-cycle acknowledge of an accepted clear.
- armed  output  1  high while in ARMED.
- tamper  output  1  sticky trip flag.
- tamper_pulse  output  1  one-cycle pulse on each trip.
- locked  output  1  permanent lockout flag.
- event_cnt  output  CNT_W  trip count, saturating.
- state  output  3  encoded FSM state for debug.

Behaviour:
- Reset (RST_N=0 at posedge):
  - State DISARMED (code 0).
  - Sync chain, warm-up counter and run counter all 0.
  - All outputs 0.
  - Reset overrides everything, including LOCKED.
- Synchronizer:
  - alarm_s is Alarm delayed by SYNC_STAGES flops.
  - All FSM decisions use alarm_s only.
- State codes: DISARMED=0, WARMUP=1, ARMED=2, TRIPPED=3, LOCKED=4.
- DISARMED:
  - Counters held at 0.
  - en=1 → WARMUP next cycle.
- WARMUP:
  - alarm_s=0: warm-up counter increments.
  - alarm_s=1: warm-up counter clears to 0.
  - alarm_s=0 with counter == WARMUP_CYCLES-1 → ARMED; warm-up counter clears.
- ARMED:
  - armed=1.
  - alarm_s=1: run counter increments.
  - alarm_s=0: run counter clears.
  - alarm_s=1 with run counter == TRIP_THRESH-1 → trip.
- Trip (transition cycle out of ARMED):
  - event_cnt increments, saturating at 2^CNT_W-1.
  - tamper is set.
  - tamper_pulse is high for exactly one cycle, coincident with the state change.
  - Run counter clears.
  - Next state is LOCKED if LOCK_COUNT≠0 and the new event_cnt ≥ LOCK_COUNT; otherwise TRIPPED.
- TRIPPED:
  - tamper stays 1.
  - Further alarms are ignored: no additional count or pulse.
  - clr_req=1 → clr_ack=1 for one cycle, tamper=0, next state WARMUP if en=1 else DISARMED.
  - Warm-up must be fully re-earned after a clear.
- LOCKED:
  - locked=1, tamper=1.
  - clr_req ignored, no clr_ack.
  - en ignored.
  - Exit only via RST_N.
- en=0 in WARMUP or ARMED → DISARMED next cycle, counters cleared.
- en=0 has no effect in TRIPPED or LOCKED; the trip is sticky regardless of enable.
- Simultaneous events:
  - en=0 and a trip condition in the same ARMED cycle: the trip wins.
  - clr_req and en=0 in TRIPPED: go to DISARMED with clr_ack.
- clr_req held high continuously:
  - Acknowledged once per TRIPPED visit.
  - Has no effect in other states; clr_ack stays 0 there.
- Registers and counter widths:
  - All outputs are registered.
  - armed, locked and state reflect the current state register.
  - Counter widths are clog2-sized; no wrap is permitted. The warm-up counter and run counter never exceed their thresholds.

Test Plan:
- Reset then en=1, Alarm held 1 for 50 cycles → state stays WARMUP, armed=0, tamper=0, event_cnt=0.
- Alarm=0 steady after en=1 with defaults → armed=1 exactly 2 (sync) + 1 (enter WARMUP) + 16 cycles after the first clean sample, measured relative to when alarm_s goes low. Inject a single alarm cycle at warm-up count 10 → warm-up restarts and arming is delayed by 11 cycles.
- ARMED with TRIP_THRESH=3: 2-cycle Alarm pulse → no trip, run counter clears. 3-cycle pulse → tamper_pulse one cycle, tamper=1, event_cnt=1, state=3.
- TRIPPED, then assert clr_req for 5 cycles → a single clr_ack pulse, tamper=0, state=1. Re-arm after 16 clean cycles.
- LOCK_COUNT=4: trip/clear four times → fourth trip goes directly to state 4 with locked=1 and event_cnt=4. clr_req and en=0 produce no ack and no change. RST_N=0 → all outputs 0.
- CNT_W=2, LOCK_COUNT=0: six trip/clear cycles → event_cnt saturates at 3 and never locks. en=0 while TRIPPED → tamper remains 1.
